sand_brush_painter: RTL

- Turns a user "paint" request into a burst of cell writes into the game-state RAM (the simulation's working buffer).
- Paints a square brush centred on the cursor, one cell at a time.
- Sits beside the game state controller and consumes its draw_en_o grant. It only drives the RAM port while that grant is high, during the controller's WAIT window, so painting never collides with next-state computation or the VRAM copy.

---
 rtl/sand_brush_painter.sv | 235 +++++++++++++++++++++++
 1 files changed

// File: rtl/sand_brush_painter.sv
// ---------------------------------------------------------------------------
// sand_brush_painter
//
// Turns a paint request into a burst of cell writes into the game-state RAM.
// A square brush of side 2*BRUSH_RADIUS+1 is centred on the latched cursor.
// Cells are visited in row-major order, starting at the top-left cell.
//
// Each cell normally takes two cycles:
//   READ  : the cell address is presented on the read port.
//   WRITE : the cell is written only if it is empty, or if the stroke erases
//           (material 0).
// Clipped (out-of-range) cells keep their slot but are never read or written.
// The block drives the RAM only while draw_en_i (the controller's grant) is
// high. Losing the grant mid-stroke abandons the stroke.
//
// Optional build macro:
//   BRUSH_OVERWRITE_EN - removes the READ state. Each cell takes one cycle and
//                        is written unconditionally when it is in range.
//
// Ports:
//   clk_i            system clock
//   reset_i          asynchronous active-low reset
//   draw_en_i        RAM-access grant from the game state controller
//   paint_i          user paint request (level)
//   cursor_x_i       cursor column (may exceed the playfield)
//   cursor_y_i       cursor row (may exceed the playfield)
//   material_i       cell value to paint, 0 = erase
//   ram_rd_data_i    RAM read data, one cycle after the read address
//   ram_rd_address_o RAM read address
//   ram_wr_address_o RAM write address
//   ram_wr_data_o    RAM write data
//   ram_wr_en_o      RAM write strobe
//   busy_o           stroke in progress
//   done_o           one-cycle pulse on normal stroke completion
// ---------------------------------------------------------------------------
module sand_brush_painter #(
    parameter int ACTIVE_COLUMNS = 640,
    parameter int ACTIVE_ROWS    = 480,
    parameter int ADDR_WIDTH     = $clog2(ACTIVE_COLUMNS * ACTIVE_ROWS),
    parameter int DATA_WIDTH     = 2,
    parameter int BRUSH_RADIUS   = 2
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    input  logic                  draw_en_i,
    input  logic                  paint_i,
    input  logic [9:0]            cursor_x_i,
    input  logic [8:0]            cursor_y_i,
    input  logic [DATA_WIDTH-1:0] material_i,
    input  logic [DATA_WIDTH-1:0] ram_rd_data_i,
    output logic [ADDR_WIDTH-1:0] ram_rd_address_o,
    output logic [ADDR_WIDTH-1:0] ram_wr_address_o,
    output logic [DATA_WIDTH-1:0] ram_wr_data_o,
    output logic                  ram_wr_en_o,
    output logic                  busy_o,
    output logic                  done_o
);

    localparam logic signed [10:0] RAD_POS = 11'(BRUSH_RADIUS);
    localparam logic signed [10:0] RAD_NEG = 11'(-BRUSH_RADIUS);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_WRITE = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    state_e                  state_q, state_d;
    logic [9:0]              cx_q, cx_d;
    logic [8:0]              cy_q, cy_d;
    logic [DATA_WIDTH-1:0]   mat_q, mat_d;
    logic signed [10:0]      dx_q, dx_d;
    logic signed [10:0]      dy_q, dy_d;
    logic                    busy_q, busy_d;
    logic                    done_q, done_d;
`ifndef BRUSH_OVERWRITE_EN
    logic                    skip_q, skip_d;
`endif

    logic signed [10:0]      x_s;
    logic signed [10:0]      y_s;
    logic                    in_range_s;
    logic [ADDR_WIDTH-1:0]   addr_s;
    logic                    last_cell_s;
    logic                    wr_ok_s;

    // Current cell coordinates, range test and linear address.
    always_comb begin
        // Signed 11-bit sums: a cursor near the top of its range may wrap
        // negative, which the range test then rejects anyway.
        x_s         = $signed({1'b0, cx_q}) + dx_q;
        y_s         = $signed({2'b00, cy_q}) + dy_q;
        in_range_s  = (x_s[10] == 1'b0) && (int'(x_s) < ACTIVE_COLUMNS) &&
                      (y_s[10] == 1'b0) && (int'(y_s) < ACTIVE_ROWS);
        addr_s      = ADDR_WIDTH'(int'(y_s) * ACTIVE_COLUMNS + int'(x_s));
        last_cell_s = (dx_q == RAD_POS) && (dy_q == RAD_POS);
    end

    // Decide whether the cell in its WRITE slot actually gets written.
    always_comb begin
`ifdef BRUSH_OVERWRITE_EN
        wr_ok_s = (state_q == ST_WRITE) && draw_en_i && in_range_s;
`else
        // Sand only lands in empty cells; erasing always goes through.
        wr_ok_s = (state_q == ST_WRITE) && draw_en_i && !skip_q &&
                  ((ram_rd_data_i == {DATA_WIDTH{1'b0}}) ||
                   (mat_q == {DATA_WIDTH{1'b0}}));
`endif
    end

    // Next-state logic for the stroke sequencer.
    always_comb begin
        state_d = state_q;
        cx_d    = cx_q;
        cy_d    = cy_q;
        mat_d   = mat_q;
        dx_d    = dx_q;
        dy_d    = dy_q;
`ifndef BRUSH_OVERWRITE_EN
        skip_d  = skip_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (draw_en_i && paint_i) begin
                    cx_d  = cursor_x_i;
                    cy_d  = cursor_y_i;
                    mat_d = material_i;
                    dx_d  = RAD_NEG;
                    dy_d  = RAD_NEG;
`ifdef BRUSH_OVERWRITE_EN
                    state_d = ST_WRITE;
`else
                    state_d = ST_READ;
`endif
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_READ: begin
                if (!draw_en_i) begin
                    state_d = ST_IDLE;
                end else begin
`ifndef BRUSH_OVERWRITE_EN
                    skip_d = !in_range_s;
`endif
                    state_d = ST_WRITE;
                end
            end
            ST_WRITE: begin
                if (!draw_en_i) begin
                    state_d = ST_IDLE;
                end else if (last_cell_s) begin
                    state_d = ST_DONE;
                end else begin
                    if (dx_q == RAD_POS) begin
                        dx_d = RAD_NEG;
                        dy_d = dy_q + 11'sd1;
                    end else begin
                        dx_d = dx_q + 11'sd1;
                    end
`ifdef BRUSH_OVERWRITE_EN
                    state_d = ST_WRITE;
`else
                    state_d = ST_READ;
`endif
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        // Status flags follow the next state so they can be registered.
        busy_d = (state_d == ST_READ) || (state_d == ST_WRITE);
        done_d = (state_d == ST_DONE);
    end

    // State, latched stroke context and registered status flags.
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            state_q <= ST_IDLE;
            cx_q    <= 10'd0;
            cy_q    <= 9'd0;
            mat_q   <= {DATA_WIDTH{1'b0}};
            dx_q    <= 11'sd0;
            dy_q    <= 11'sd0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
`ifndef BRUSH_OVERWRITE_EN
            skip_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cx_q    <= cx_d;
            cy_q    <= cy_d;
            mat_q   <= mat_d;
            dx_q    <= dx_d;
            dy_q    <= dy_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
`ifndef BRUSH_OVERWRITE_EN
            skip_q  <= skip_d;
`endif
        end
    end

    // RAM port drive. Everything is forced to zero unless actively used.
    always_comb begin
        ram_rd_address_o = {ADDR_WIDTH{1'b0}};
        ram_wr_address_o = {ADDR_WIDTH{1'b0}};
        ram_wr_data_o    = {DATA_WIDTH{1'b0}};
        ram_wr_en_o      = 1'b0;
`ifndef BRUSH_OVERWRITE_EN
        if ((state_q == ST_READ) && draw_en_i && in_range_s) begin
            ram_rd_address_o = addr_s;
        end else begin
            ram_rd_address_o = {ADDR_WIDTH{1'b0}};
        end
`endif
        if (wr_ok_s) begin
            ram_wr_en_o      = 1'b1;
            ram_wr_address_o = addr_s;
            ram_wr_data_o    = mat_q;
        end else begin
            ram_wr_en_o      = 1'b0;
        end
    end

    assign busy_o = busy_q;
    assign done_o = done_q;

endmodule
